// File: rtl/bp_sched_pkg.sv
// rtl/bp_sched_pkg.sv - shared state encoding, sweep direction constants and width helpers for the BP scheduler
package bp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GAP   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // clog2 that never returns less than 1, so single-value fields still get a bit
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    function automatic int stg_width(input int log_n);
        return clog2_min1(log_n);
    endfunction

    function automatic int grp_width(input int log_n, input int par);
        return clog2_min1((1 << log_n) / (2 * par));
    endfunction

endpackage

// File: rtl/bp_wr_delay.sv
// rtl/bp_wr_delay.sv - fixed-depth shift register turning read issue words into write-back words
module bp_wr_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    // Shift the {valid, stage, grp, dir} word; reset wipes every slot so no stale write escapes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/bp_sched_ctrl.sv
// rtl/bp_sched_ctrl.sv - polar BP stage/iteration scheduler (optional early stop: BP_EARLY_STOP_EN)
module bp_sched_ctrl
    import bp_sched_pkg::*;
#(
    parameter  int LOG_N  = 3,
    parameter  int PAR    = 2,
    parameter  int PE_LAT = 3,
    parameter  int ITER_W = 6,
    localparam int STG_W  = stg_width(LOG_N),
    localparam int GRP_W  = grp_width(LOG_N, PAR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
`ifdef BP_EARLY_STOP_EN
    input  logic              early_stop,
`endif
    output logic              busy,
    output logic              done,
    output logic              pe_en,
    output logic              rd_en,
    output logic [STG_W-1:0]  rd_stage,
    output logic [GRP_W-1:0]  rd_grp,
    output logic              dir,
    output logic              wr_en,
    output logic [STG_W-1:0]  wr_stage,
    output logic [GRP_W-1:0]  wr_grp,
    output logic              wr_dir,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int G     = (1 << LOG_N) / (2 * PAR);
    localparam int GAP_W = clog2_min1(PE_LAT + 1);
    localparam int DW    = 2 + STG_W + GRP_W;

    sched_state_e      state;
    logic [STG_W-1:0]  stage;
    logic [GRP_W-1:0]  grp;
    logic [GAP_W-1:0]  gap_cnt;
    logic              sweep_dir;
    logic [ITER_W-1:0] iter_lim;
    logic [ITER_W:0]   iter_inc;
    logic              early_hit;
    logic              stop;
    logic              last_grp;
    logic              gap_end;
    logic [DW-1:0]     rd_word;
    logic [DW-1:0]     wr_word;

`ifdef BP_EARLY_STOP_EN
    assign early_hit = early_stop;
`else
    assign early_hit = 1'b0;
`endif

    assign last_grp = (grp == GRP_W'(G - 1));
    assign gap_end  = (gap_cnt == GAP_W'(PE_LAT));
    // One extra bit so an iteration limit at the top of the range cannot wrap the compare
    assign iter_inc = {1'b0, iter_cnt} + 1'b1;
    assign stop     = (iter_inc >= {1'b0, iter_lim}) || early_hit;

    // Main sequencer: issue a stage, drain the PE pipeline, pick the next stage or finish the iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stage     <= '0;
            grp       <= '0;
            gap_cnt   <= '0;
            sweep_dir <= DIR_L;
            iter_lim  <= '0;
            iter_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        iter_lim  <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        iter_cnt  <= '0;
                        stage     <= STG_W'(LOG_N - 1);
                        sweep_dir <= DIR_L;
                        grp       <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (last_grp) begin
                        grp     <= '0;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!gap_end) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (sweep_dir == DIR_L) begin
                        if (stage == '0) begin
                            sweep_dir <= DIR_R;
                        end else begin
                            stage <= stage - 1'b1;
                        end
                        state <= ST_ISSUE;
                    end else if (stage == STG_W'(LOG_N - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        stage <= stage + 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_CHECK: begin
                    iter_cnt <= iter_inc[ITER_W-1:0];
                    if (stop) begin
                        state <= ST_DONE;
                    end else begin
                        stage     <= STG_W'(LOG_N - 1);
                        sweep_dir <= DIR_L;
                        state     <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state == ST_ISSUE) || (state == ST_GAP) || (state == ST_CHECK);
    assign pe_en    = busy;
    assign done     = (state == ST_DONE);
    assign rd_en    = (state == ST_ISSUE);
    assign rd_stage = busy  ? stage     : '0;
    assign rd_grp   = rd_en ? grp       : '0;
    assign dir      = busy  ? sweep_dir : DIR_L;

    // Write-back address trails the read by one BRAM cycle plus the PE pipeline
    assign rd_word = {rd_en, rd_stage, rd_grp, dir};

    bp_wr_delay #(
        .DEPTH (1 + PE_LAT),
        .W     (DW)
    ) u_wr_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_word),
        .dout  (wr_word)
    );

    assign {wr_en, wr_stage, wr_grp, wr_dir} = wr_word;

endmodule

// File: tb/tb_bp_sched_ctrl.sv
// tb/tb_bp_sched_ctrl.sv - randomized self-checking bench for bp_sched_ctrl against a schedule model
module tb_bp_sched_ctrl;

    localparam int LOG_N  = 3;
    localparam int PAR    = 2;
    localparam int PE_LAT = 3;
    localparam int ITER_W = 6;
    localparam int STG_W  = bp_sched_pkg::stg_width(LOG_N);
    localparam int GRP_W  = bp_sched_pkg::grp_width(LOG_N, PAR);
    localparam int G      = (1 << LOG_N) / (2 * PAR);
    localparam int DLY    = 1 + PE_LAT;
    localparam int P      = 2 * LOG_N * (G + PE_LAT + 1) + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ITER_W-1:0] max_iter;
    logic              early_stop;
    logic              busy, done, pe_en, rd_en, dir, wr_en, wr_dir;
    logic [STG_W-1:0]  rd_stage, wr_stage;
    logic [GRP_W-1:0]  rd_grp, wr_grp;
    logic [ITER_W-1:0] iter_cnt;

    bp_sched_ctrl #(
        .LOG_N  (LOG_N),
        .PAR    (PAR),
        .PE_LAT (PE_LAT),
        .ITER_W (ITER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .max_iter   (max_iter),
`ifdef BP_EARLY_STOP_EN
        .early_stop (early_stop),
`endif
        .busy       (busy),
        .done       (done),
        .pe_en      (pe_en),
        .rd_en      (rd_en),
        .rd_stage   (rd_stage),
        .rd_grp     (rd_grp),
        .dir        (dir),
        .wr_en      (wr_en),
        .wr_stage   (wr_stage),
        .wr_grp     (wr_grp),
        .wr_dir     (wr_dir),
        .iter_cnt   (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int busy;
        int done;
        int rd;
        int stage;
        int grp;
        int dir;
        int iter;
    } exp_t;

    typedef struct {
        int v;
        int s;
        int g;
        int d;
    } rd_t;

    exp_t exp_q[$];
    exp_t cur;
    rd_t  hist[DLY];
    int   hold;
    int   n_tests;
    int   n_fail;
    int   seq[12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle schedule: each iteration is an L-sweep then an R-sweep of
    // G read cycles plus PE_LAT+1 idle cycles per stage, a check cycle, and a final done cycle
    task automatic build(input int niter);
        exp_t e;
        for (int it = 0; it < niter; it++) begin
            for (int sw = 0; sw < 2; sw++) begin
                for (int k = 0; k < LOG_N; k++) begin
                    for (int c = 0; c < G + PE_LAT + 1; c++) begin
                        e.busy  = 1;
                        e.done  = 0;
                        e.rd    = (c < G) ? 1 : 0;
                        e.stage = (sw == 0) ? (LOG_N - 1 - k) : k;
                        e.grp   = (c < G) ? c : 0;
                        e.dir   = sw;
                        e.iter  = it;
                        exp_q.push_back(e);
                    end
                end
            end
            e.busy = 1; e.done = 0; e.rd = 0; e.stage = 0; e.grp = 0; e.dir = 1; e.iter = it;
            exp_q.push_back(e);
        end
        e.busy = 0; e.done = 1; e.rd = 0; e.stage = 0; e.grp = 0; e.dir = 0; e.iter = niter;
        exp_q.push_back(e);
    endtask

    // Per-cycle compare of every output against the schedule model and its delayed read history
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold = 0;
            for (int i = 0; i < DLY; i++) hist[i] = '{0, 0, 0, 0};
            cur = '{0, 0, 0, 0, 0, 0, 0};
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = '{0, 0, 0, 0, 0, 0, hold};
        end
        if (cur.done != 0) hold = cur.iter;
        check("busy", int'(busy), cur.busy);
        check("pe_en", int'(pe_en), cur.busy);
        check("done", int'(done), cur.done);
        check("rd_en", int'(rd_en), cur.rd);
        check("iter_cnt", int'(iter_cnt), cur.iter);
        if (cur.rd != 0) begin
            check("rd_stage", int'(rd_stage), cur.stage);
            check("rd_grp", int'(rd_grp), cur.grp);
            check("dir", int'(dir), cur.dir);
        end
        if (cur.busy == 0) begin
            check("rd_stage_idle", int'(rd_stage), 0);
            check("dir_idle", int'(dir), 0);
        end
        check("wr_en", int'(wr_en), hist[DLY-1].v);
        if (hist[DLY-1].v != 0) begin
            check("wr_stage", int'(wr_stage), hist[DLY-1].s);
            check("wr_grp", int'(wr_grp), hist[DLY-1].g);
            check("wr_dir", int'(wr_dir), hist[DLY-1].d);
        end
        for (int i = DLY - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{cur.rd, cur.stage, cur.grp, cur.dir};
    end

    // One decode run; exp_done/exp_iter < 0 skip the literal pins, chk_seq pins the stage order
    task automatic run(input int mi, input int es, input int pulse, input int exp_done,
                       input int exp_iter, input int chk_seq);
        int eff, niter, len, done_j, pj;
        int seen[$];
        eff   = (mi == 0) ? 1 : mi;
        niter = eff;
`ifdef BP_EARLY_STOP_EN
        if (es > 0 && es < niter) niter = es;
`endif
        len = niter * P + 1;
        pj  = (pulse != 0) ? $urandom_range(2, len - 1) : 0;
        @(negedge clk); #1;
        start    = 1'b1;
        max_iter = ITER_W'(mi);
        build(niter);
        if (exp_done >= 0) check("model_len", exp_q.size(), exp_done);
        done_j = -1;
        for (int j = 1; j <= len + 3; j++) begin
            @(negedge clk); #1;
            start      = (j == pj) ? 1'b1 : 1'b0;
            early_stop = (es > 0 && j == es * P) ? 1'b1 : 1'b0;
            if (j == 3) max_iter = ITER_W'($urandom);
            if (rd_en) seen.push_back(int'(rd_stage));
            if (done && done_j < 0) done_j = j;
        end
        start      = 1'b0;
        early_stop = 1'b0;
        check("done_seen", (done_j > 0) ? 1 : 0, 1);
        if (exp_done >= 0) check("done_cycle", done_j, exp_done);
        if (exp_iter >= 0) check("iter_final", int'(iter_cnt), exp_iter);
        if (chk_seq != 0) begin
            check("seq_len", seen.size(), 12);
            for (int i = 0; i < 12 && i < seen.size(); i++) check("rd_stage_seq", seen[i], seq[i]);
        end
    endtask

    initial begin
        int ok;
        n_tests    = 0;
        n_fail     = 0;
        seq        = '{2, 2, 1, 1, 0, 0, 0, 0, 1, 1, 2, 2};
        rst_n      = 1'b0;
        start      = 1'b0;
        max_iter   = '0;
        early_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_en", int'(wr_en), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(1, 0, 0, 38, 1, 1);
        run(0, 0, 0, 38, 1, 1);
`ifdef BP_EARLY_STOP_EN
        run(5, 2, 0, 75, 2, 0);
`else
        run(5, 2, 0, 186, 5, 0);
`endif
        run(2, 0, 1, 2 * P + 1, 2, 0);

        // Reset ten cycles into a run, then a clean rerun of the first scenario
        @(negedge clk); #1;
        start    = 1'b1;
        max_iter = ITER_W'(1);
        build(1);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        ok = (busy == 0 && rd_en == 0 && wr_en == 0 && done == 0 && pe_en == 0 &&
              rd_stage == 0 && wr_stage == 0 && iter_cnt == 0) ? 1 : 0;
        check("reset_immediate", ok, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run(1, 0, 0, 38, 1, 1);

        for (int r = 0; r < 8; r++) begin
            run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), -1, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
